// File: rtl/stack_unit.sv
// Hardware operand stack for the nanoRisc datapath.
// Provides the ALU's top-of-stack operands and accepts pushes of pushr/pushi/ALU
// results. Pops are applied before the push within one cycle. A request that
// would underflow or overflow is dropped whole and raises a sticky error flag.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_en,
  input  logic              s_reset,
  input  logic              s_en_op,
  input  logic              s_op,
  input  logic              s_en_noOpPop,
  input  logic              s_en_popQuantity,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] second,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic              ovf_q;
  logic              unf_q;

  logic [1:0]        npop;
  logic              npush;
  logic [CNT_W-1:0]  npop_ext;
  logic [CNT_W-1:0]  sp_after_pop;
  logic [CNT_W-1:0]  sp_next;
  logic              underflow;
  logic              overflow;
  logic              do_op;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     second_idx;

  // Work out this cycle's pop/push counts and whether the request is legal.
  // Underflow takes precedence, so overflow is only considered when the pops fit.
  always_comb begin
    npop = 2'd0;
    if (s_en_noOpPop) begin
      npop = s_en_popQuantity ? 2'd2 : 2'd1;
    end
    if (s_en_op && !s_op) begin
      npop = npop + 2'd1;
    end
    npush        = s_en_op & s_op;
    npop_ext     = CNT_W'(npop);
    underflow    = (npop_ext > sp);
    sp_after_pop = sp - npop_ext;
    overflow     = npush && !underflow && (sp_after_pop == CNT_W'(DEPTH));
    sp_next      = sp_after_pop + CNT_W'(npush);
    do_op        = s_en && !s_reset && !underflow && !overflow;
    wr_idx       = AW'(sp_after_pop);
  end

  // Stack pointer and sticky error flags; clear has priority over any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (s_en) begin
      if (s_reset) begin
        sp    <= '0;
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else if (underflow) begin
        unf_q <= 1'b1;
      end else if (overflow) begin
        ovf_q <= 1'b1;
      end else begin
        sp <= sp_next;
      end
    end
  end

  // Storage array is left unreset; entries above sp are never presented.
  always_ff @(posedge clk) begin
    if (do_op && npush) begin
      mem[wr_idx] <= data_in;
    end
  end

  // Outputs come only from registered state, with invalid entries forced to 0.
  always_comb begin
    top_idx    = AW'(sp - CNT_W'(1));
    second_idx = AW'(sp - CNT_W'(2));
    top        = (sp >= CNT_W'(1)) ? mem[top_idx]    : '0;
    second     = (sp >= CNT_W'(2)) ? mem[second_idx] : '0;
    count      = sp;
    empty      = (sp == '0);
    full       = (sp == CNT_W'(DEPTH));
    ovf        = ovf_q;
    unf        = unf_q;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit with a queue-based reference stack and a
// scoreboard of expected output snapshots.
module tb_stack_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              s_en;
  logic              s_reset;
  logic              s_en_op;
  logic              s_op;
  logic              s_en_noOpPop;
  logic              s_en_popQuantity;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] top;
  logic [DATA_W-1:0] second;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              ovf;
  logic              unf;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] second;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;
  } snap_t;

  snap_t             exp_q[$];
  logic [DATA_W-1:0] model_stk[$];
  logic              model_ovf;
  logic              model_unf;
  int                checks;
  int                errors;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_en             (s_en),
    .s_reset          (s_reset),
    .s_en_op          (s_en_op),
    .s_op             (s_op),
    .s_en_noOpPop     (s_en_noOpPop),
    .s_en_popQuantity (s_en_popQuantity),
    .data_in          (data_in),
    .top              (top),
    .second           (second),
    .count            (count),
    .empty            (empty),
    .full             (full),
    .ovf              (ovf),
    .unf              (unf)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] time limit reached");
  end

  // Queue the snapshot the reference stack says the DUT should now show.
  task automatic expectSnapshot(input string tag);
    snap_t s;
    int n;
    n        = model_stk.size();
    s.tag    = tag;
    s.top    = (n >= 1) ? model_stk[n-1] : '0;
    s.second = (n >= 2) ? model_stk[n-2] : '0;
    s.count  = CNT_W'(n);
    s.empty  = (n == 0);
    s.full   = (n == DEPTH);
    s.ovf    = model_ovf;
    s.unf    = model_unf;
    exp_q.push_back(s);
  endtask

  // Drive one cycle of control, advance the reference stack, then let the edge pass.
  task automatic applyStimulus(input logic en, input logic clr, input logic en_op,
                               input logic op, input logic nop, input logic pq,
                               input logic [DATA_W-1:0] d, input string tag);
    int npop;
    int npush;
    s_en             = en;
    s_reset          = clr;
    s_en_op          = en_op;
    s_op             = op;
    s_en_noOpPop     = nop;
    s_en_popQuantity = pq;
    data_in          = d;
    if (en) begin
      if (clr) begin
        model_stk.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
      end else begin
        npop  = (nop ? (pq ? 2 : 1) : 0) + ((en_op && !op) ? 1 : 0);
        npush = (en_op && op) ? 1 : 0;
        if (npop > model_stk.size()) begin
          model_unf = 1'b1;
        end else if (npush == 1 && (model_stk.size() - npop) == DEPTH) begin
          model_ovf = 1'b1;
        end else begin
          for (int i = 0; i < npop; i++) void'(model_stk.pop_back());
          if (npush == 1) model_stk.push_back(d);
        end
      end
    end
    expectSnapshot(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Pop the oldest expected snapshot and compare every output against it.
  task automatic checkOutput();
    snap_t s;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    s = exp_q.pop_front();
    checkField(s.tag, "top",    top,                s.top);
    checkField(s.tag, "second", second,             s.second);
    checkField(s.tag, "count",  DATA_W'(count),     DATA_W'(s.count));
    checkField(s.tag, "empty",  DATA_W'(empty),     DATA_W'(s.empty));
    checkField(s.tag, "full",   DATA_W'(full),      DATA_W'(s.full));
    checkField(s.tag, "ovf",    DATA_W'(ovf),       DATA_W'(s.ovf));
    checkField(s.tag, "unf",    DATA_W'(unf),       DATA_W'(s.unf));
  endtask

  // Directed sequence covering push/pop, combined consume+push, limits and clears.
  initial begin
    checks           = 0;
    errors           = 0;
    model_ovf        = 1'b0;
    model_unf        = 1'b0;
    rst_n            = 1'b0;
    s_en             = 1'b0;
    s_reset          = 1'b0;
    s_en_op          = 1'b0;
    s_op             = 1'b0;
    s_en_noOpPop     = 1'b0;
    s_en_popQuantity = 1'b0;
    data_in          = '0;

    #12;
    expectSnapshot("reset"); checkOutput();
    rst_n = 1'b1;
    #2;

    $display("[TB] basic pushes");
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h11, "push11"); checkOutput();
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h22, "push22"); checkOutput();
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h33, "push33"); checkOutput();

    $display("[TB] consume two and push result");
    applyStimulus(1, 0, 1, 1, 1, 1, 8'h55, "alu2push"); checkOutput();

    $display("[TB] consume one plus explicit pop");
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h66, "push66");  checkOutput();
    applyStimulus(1, 0, 1, 0, 1, 0, 8'h00, "nop1pop"); checkOutput();

    $display("[TB] fill and overflow");
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, "clear1"); checkOutput();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, 1, 1, 0, 0, DATA_W'(8'h80 + i), "fill"); checkOutput();
    end
    applyStimulus(1, 0, 1, 1, 0, 0, 8'hAA, "ovfpush");  checkOutput();
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, "popafter"); checkOutput();
    applyStimulus(1, 0, 1, 1, 1, 0, 8'hBB, "alu1full"); checkOutput();

    $display("[TB] underflow");
    applyStimulus(1, 1, 0, 0, 0, 0, 8'h00, "clear2");   checkOutput();
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, "popempty"); checkOutput();
    applyStimulus(1, 0, 1, 1, 1, 1, 8'h77, "unfprio");  checkOutput();
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h01, "push01");   checkOutput();
    applyStimulus(1, 0, 0, 0, 1, 1, 8'h00, "unf2of1");  checkOutput();

    $display("[TB] clear overrides push");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 1, 1, 0, 0, DATA_W'(8'h40 + i), "to5"); checkOutput();
    end
    applyStimulus(1, 1, 1, 1, 0, 0, 8'hCC, "clrpush"); checkOutput();

    $display("[TB] disabled and idle cycles");
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h21, "pushA");  checkOutput();
    applyStimulus(0, 0, 1, 1, 0, 0, 8'h99, "dispush"); checkOutput();
    applyStimulus(0, 1, 1, 0, 1, 1, 8'h00, "disclr");  checkOutput();
    applyStimulus(1, 0, 0, 1, 0, 1, 8'h98, "idle");    checkOutput();

    $display("[TB] asynchronous reset between edges");
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h22, "pushB"); checkOutput();
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h23, "pushC"); checkOutput();
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h24, "pushD"); checkOutput();
    s_en    = 1'b0;
    s_en_op = 1'b0;
    #3;
    rst_n = 1'b0;
    model_stk.delete();
    model_ovf = 1'b0;
    model_unf = 1'b0;
    #1;
    expectSnapshot("asyncrst"); checkOutput();
    #3;
    rst_n = 1'b1;
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h5A, "postrst"); checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack for the nanoRisc datapath. It sits directly downstream of the control unit and consumes its s_* control group.
- It supplies the ALU's stack-top operands, and pushes pushr/pushi/ALU results selected by the external stack data mux.
- It provides push, single pop, and post-ALU operand consumption (1 or 2 entries), plus synchronous clear and sticky error flags.

Parameters:
DATA_W, 8, width of each stack entry
DEPTH, 16, number of entries (power of two, >=4)
CNT_W, $clog2(DEPTH+1), width of the occupancy count

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_en  in  1  stack enable; no state change when 0
s_reset  in  1  synchronous clear (qualified by s_en)
s_en_op  in  1  explicit push/pop request
s_op  in  1  1 = push data_in, 0 = pop one entry
s_en_noOpPop  in  1  consume ALU operands this cycle
s_en_popQuantity  in  1  0 = consume 1 entry, 1 = consume 2 entries
data_in  in  DATA_W  value to push (already muxed upstream)
top  out  DATA_W  entry at sp-1; 0 when count<1
second  out  DATA_W  entry at sp-2; 0 when count<2
count  out  CNT_W  current occupancy 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
ovf  out  1  sticky overflow flag
unf  out  1  sticky underflow flag

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- On rst_n=0: sp/count=0, ovf=0, unf=0, top=0, second=0, empty=1, full=0.
  - Storage array needs no reset; outputs are gated to 0 when entries are invalid.
- State is the array plus sp (CNT_W bits). top, second, count, empty and full are combinational from registered state.
  - Effects are visible the cycle after the enabling edge (1-cycle latency).
- s_en=0: hold all state regardless of other inputs.
- s_en=1, s_reset=1: sp<=0, ovf<=0, unf<=0. All other requests in that cycle are ignored. Highest priority.
- s_en=1, s_reset=0: per cycle, compute these counts:
  - npop = (s_en_noOpPop ? 1+s_en_popQuantity : 0) + (s_en_op & ~s_op ? 1 : 0)
  - npush = s_en_op & s_op
- Pops are applied first, then the push. The resulting new sp = sp - npop + npush.
  - The pushed value is written at index sp-npop.
  - Example (ALU in stack mode, repo on): pop 2, push result, net sp-1. The result lands where the old second was.
- Underflow: if npop > sp, the whole cycle's operation is suppressed (no write, sp unchanged) and unf<=1.
- Overflow: if npush=1 and sp-npop == DEPTH, the whole operation is suppressed and ovf<=1.
- Underflow is checked before overflow; only one flag is set per cycle.
- Flags are sticky until s_reset (with s_en) or rst_n.
- s_en=1 with no request: no change.
- Simultaneous push and pop through s_en_op is impossible (single s_op bit). Combining noOpPop with an explicit pop is legal and the counts add.
- Wrap-around: sp never wraps. It saturates by suppression at 0 and DEPTH.
- Reset asserted mid-operation clears state immediately, independent of clk. A request on the edge where rst_n deasserts is ignored.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 (s_en=1, s_en_op=1, s_op=1) -> top=0x33, second=0x22, count=3, empty=0.
- With [0x11,0x22,0x33]: noOpPop=1, popQuantity=1, push 0x55 in the same cycle -> count=2, top=0x55, second=0x11, no flags.
- Fill to DEPTH=16, then push 0xAA -> count stays 16, full=1, ovf=1, top unchanged. A subsequent pop succeeds and ovf stays 1.
- Empty stack: pop -> unf=1, count=0, top=0. Then with 1 entry, noOpPop with popQuantity=1 -> suppressed, count stays 1.
- With 5 entries and flags set, s_en=1 and s_reset=1 with a push requested -> count=0, ovf=0, unf=0, push ignored.
- Push with s_en=0 -> no change. Assert rst_n=0 between clock edges with count=4 -> count=0 immediately, outputs 0.
